// File: rtl/visor_observe_engine.sv
// Sequencer that reads target registers at a breakpoint by injecting "rDEST = rN" moves
// through the diverted code bus, then restores EXR from its shadow and releases the target.
module visor_observe_engine #(
    parameter int unsigned WORD_W        = 16,
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned REG_W         = 4,
    parameter int unsigned MOVE_BASE     = 'h3c00,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_W-1:0]  req_reg,
    input  logic              req_dump,
    input  logic              tg_halted,
    input  logic [WORD_W-1:0] exr_shadow,
    input  logic [WORD_W-1:0] tg_to_visor_reg,
    output logic [WORD_W-1:0] tg_code_in,
    output logic              divert_code_bus,
    output logic              tg_debug_hold,
    output logic              tg_force_load_exr,
    output logic              tg_force_exec,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [REG_W-1:0]  rsp_reg,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              err
);

    localparam logic [WORD_W-1:0] MoveWord   = WORD_W'(MOVE_BASE);
    localparam logic [REG_W:0]    NumRegs    = (REG_W + 1)'(NUM_REGS);
    localparam logic [REG_W-1:0]  LastIdx    = REG_W'(NUM_REGS - 1);
    localparam logic [3:0]        SettleInit = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle, StDivert, StLoad, StExec, StSettle, StCapture, StRespond, StRestore, StRelease
    } state_e;

    state_e            state_q;
    logic [REG_W-1:0]  idx_q;
    logic              dump_q;
    logic [3:0]        settle_q;
    logic              restore_first_q;

    logic [REG_W-1:0]  start_idx;
    logic [REG_W-1:0]  next_idx;
    logic              bad_reg;

    assign start_idx = req_dump ? '0 : req_reg;
    assign next_idx  = idx_q + REG_W'(1);
    assign bad_reg   = !req_dump && ({1'b0, req_reg} >= NumRegs);

    function automatic logic [WORD_W-1:0] move_word(input logic [REG_W-1:0] i);
        return MoveWord | WORD_W'(i);
    endfunction

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q           <= StIdle;
            idx_q             <= '0;
            dump_q            <= 1'b0;
            settle_q          <= '0;
            restore_first_q   <= 1'b0;
            req_ready         <= 1'b1;
            tg_code_in        <= '0;
            divert_code_bus   <= 1'b0;
            tg_debug_hold     <= 1'b0;
            tg_force_load_exr <= 1'b0;
            tg_force_exec     <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_reg           <= '0;
            rsp_data          <= '0;
            rsp_last          <= 1'b0;
            busy              <= 1'b0;
            err               <= 1'b0;
        end else begin
            tg_force_load_exr <= 1'b0;
            tg_force_exec     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (!tg_halted || bad_reg) begin
                            err <= 1'b1;
                        end else begin
                            err             <= 1'b0;
                            idx_q           <= start_idx;
                            dump_q          <= req_dump;
                            req_ready       <= 1'b0;
                            busy            <= 1'b1;
                            divert_code_bus <= 1'b1;
                            tg_debug_hold   <= 1'b1;
                            tg_code_in      <= move_word(start_idx);
                            state_q         <= StDivert;
                        end
                    end
                end
                StDivert: begin
                    tg_force_load_exr <= 1'b1;
                    state_q           <= StLoad;
                end
                StLoad: begin
                    tg_force_exec <= 1'b1;
                    state_q       <= StExec;
                end
                StExec: begin
                    settle_q <= SettleInit;
                    state_q  <= StSettle;
                end
                StSettle: begin
                    if (settle_q == 4'd0) begin
                        state_q <= StCapture;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                StCapture: begin
                    rsp_data  <= tg_to_visor_reg;
                    rsp_reg   <= idx_q;
                    rsp_last  <= !dump_q || (idx_q == LastIdx);
                    rsp_valid <= 1'b1;
                    state_q   <= StRespond;
                end
                StRespond: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            // EXR still holds the injected move; put the real one back.
                            restore_first_q   <= 1'b1;
                            tg_code_in        <= exr_shadow;
                            tg_force_load_exr <= 1'b1;
                            state_q           <= StRestore;
                        end else begin
                            idx_q      <= next_idx;
                            tg_code_in <= move_word(next_idx);
                            state_q    <= StDivert;
                        end
                    end
                end
                StRestore: begin
                    if (restore_first_q) begin
                        restore_first_q <= 1'b0;
                        tg_code_in      <= exr_shadow;
                    end else begin
                        divert_code_bus <= 1'b0;
                        tg_debug_hold   <= 1'b0;
                        tg_code_in      <= '0;
                        state_q         <= StRelease;
                    end
                end
                StRelease: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_visor_observe_engine.sv
// Bench for visor_observe_engine: a behavioural target (register file, EXR, settle delay)
// answers the injected moves; responses, pulses and timing are checked against it.
module tb_visor_observe_engine;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic sysclk = 1'b0;
    logic sysreset;
    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;

    // Default instance
    logic        req_valid, req_ready, req_dump, tg_halted;
    logic [3:0]  req_reg, rsp_reg;
    logic [15:0] exr_shadow, tg_to_visor_reg, tg_code_in, rsp_data;
    logic        divert_code_bus, tg_debug_hold, tg_force_load_exr, tg_force_exec;
    logic        rsp_valid, rsp_ready, rsp_last, busy, err;
    logic [15:0] regs [16];

    // Swept instance
    logic        b_req_valid, b_req_ready, b_req_dump, b_tg_halted;
    logic [3:0]  b_req_reg, b_rsp_reg;
    logic [31:0] b_exr_shadow, b_tg_to_visor_reg, b_tg_code_in, b_rsp_data;
    logic        b_divert_code_bus, b_tg_debug_hold, b_tg_force_load_exr, b_tg_force_exec;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_last, b_busy, b_err;
    logic [31:0] b_regs [8];

    visor_observe_engine dut (
        .sysclk(sysclk), .sysreset(sysreset), .req_valid(req_valid), .req_ready(req_ready),
        .req_reg(req_reg), .req_dump(req_dump), .tg_halted(tg_halted), .exr_shadow(exr_shadow),
        .tg_to_visor_reg(tg_to_visor_reg), .tg_code_in(tg_code_in),
        .divert_code_bus(divert_code_bus), .tg_debug_hold(tg_debug_hold),
        .tg_force_load_exr(tg_force_load_exr), .tg_force_exec(tg_force_exec),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_reg(rsp_reg), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy), .err(err)
    );

    visor_observe_engine #(
        .WORD_W(32), .NUM_REGS(8), .REG_W(4), .MOVE_BASE('h3c00), .SETTLE_CYCLES(S1)
    ) dut_b (
        .sysclk(sysclk), .sysreset(sysreset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_reg(b_req_reg), .req_dump(b_req_dump), .tg_halted(b_tg_halted),
        .exr_shadow(b_exr_shadow), .tg_to_visor_reg(b_tg_to_visor_reg),
        .tg_code_in(b_tg_code_in), .divert_code_bus(b_divert_code_bus),
        .tg_debug_hold(b_tg_debug_hold), .tg_force_load_exr(b_tg_force_load_exr),
        .tg_force_exec(b_tg_force_exec), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_reg(b_rsp_reg), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last), .busy(b_busy),
        .err(b_err)
    );

    task automatic test_reset();
        sysreset = 1'b1;
        repeat (2) @(negedge sysclk);
        checks++;
        if ({req_ready, divert_code_bus, tg_debug_hold, tg_force_load_exr, tg_force_exec,
             rsp_valid, rsp_last, busy, err} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100000000", {req_ready, divert_code_bus,
                     tg_debug_hold, tg_force_load_exr, tg_force_exec, rsp_valid, rsp_last,
                     busy, err});
        end
        checks++;
        if ({tg_code_in, rsp_data, rsp_reg} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h want 0", tg_code_in, rsp_data, rsp_reg);
        end
        sysreset = 1'b0;
        @(negedge sysclk);
        checks++;
        if ({req_ready, busy, divert_code_bus, b_req_ready, b_busy, b_divert_code_bus,
             b_tg_code_in} !== {6'b100100, 32'h0}) begin
            errors++;
            $display("FAIL reset_idle: got %b %h want 100100 0", {req_ready, busy,
                     divert_code_bus, b_req_ready, b_busy, b_divert_code_bus}, b_tg_code_in);
        end
    endtask

    // One request on the default instance; bp_mode 0 = ready high, 1 = stall 5 cycles on
    // the first response, 2 = random ready.
    task automatic run_txn(input logic dump, input logic [3:0] r, input int bp_mode,
                           input bit exact);
        int n_exp, n_rsp, exec_cyc, restores, div_cycles, first_valid, bp_left, stalls;
        logic [3:0]  exp_idx, exec_idx, p_reg;
        logic [15:0] exr, p_data;
        logic        p_last, p_stall, p_valid, have_exec, div_fell, done;
        n_exp = dump ? 16 : 1;
        n_rsp = 0; exec_cyc = -100; restores = 0; div_cycles = 0; first_valid = -1;
        bp_left = 5; stalls = 0;
        exp_idx = dump ? 4'd0 : r; exec_idx = '0; p_reg = '0; exr = '0; p_data = '0;
        p_last = 0; p_stall = 0; p_valid = 0; have_exec = 0; div_fell = 0; done = 0;
        req_valid = 1'b1; req_reg = r; req_dump = dump; rsp_ready = (bp_mode == 0);
        @(negedge sysclk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == 1) begin
                checks++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL accept: err=%b busy=%b want err=0 busy=1", err, busy);
                end
            end
            if (!busy) begin
                done = 1;
                break;
            end
            checks++;
            if (divert_code_bus !== tg_debug_hold) begin
                errors++;
                $display("FAIL hold_vs_divert: hold=%b divert=%b want equal", tg_debug_hold,
                         divert_code_bus);
            end
            if (divert_code_bus) begin
                checks++;
                if (div_fell) begin
                    errors++;
                    $display("FAIL divert_gap: divert=1 after drop at cycle %0d, want 0", cyc);
                end
                div_cycles++;
            end else if (div_cycles > 0) begin
                div_fell = 1;
            end
            if (tg_force_load_exr) begin
                checks++;
                if (n_rsp == n_exp) begin
                    restores++;
                    if (tg_code_in !== exr_shadow) begin
                        errors++;
                        $display("FAIL restore_code: got %h want %h", tg_code_in, exr_shadow);
                    end
                end else begin
                    exr = tg_code_in;
                    if (tg_code_in !== (16'h3c00 | 16'(exp_idx))) begin
                        errors++;
                        $display("FAIL load_code: got %h want %h", tg_code_in,
                                 16'h3c00 | 16'(exp_idx));
                    end
                end
            end
            if (tg_force_exec) begin
                checks++;
                if (tg_code_in !== exr) begin
                    errors++;
                    $display("FAIL exec_code: got %h want %h", tg_code_in, exr);
                end
                exec_cyc = cyc; exec_idx = exr[3:0]; have_exec = 1;
            end
            if (rsp_valid) begin
                checks++;
                if (tg_force_load_exr || tg_force_exec) begin
                    errors++;
                    $display("FAIL force_in_respond: load=%b exec=%b want 0 0",
                             tg_force_load_exr, tg_force_exec);
                end
                if (!p_valid) begin
                    checks++;
                    if (cyc != exec_cyc + S0 + 2) begin
                        errors++;
                        $display("FAIL capture_timing: valid at %0d want %0d", cyc,
                                 exec_cyc + S0 + 2);
                    end
                    if (first_valid < 0) first_valid = cyc;
                end
                if (p_stall) begin
                    checks++;
                    if ({rsp_reg, rsp_data, rsp_last} !== {p_reg, p_data, p_last}) begin
                        errors++;
                        $display("FAIL rsp_stable: got %h/%h/%b want %h/%h/%b", rsp_reg,
                                 rsp_data, rsp_last, p_reg, p_data, p_last);
                    end
                end
            end
            case (bp_mode)
                0: rsp_ready = 1'b1;
                1: begin
                    if (rsp_valid && bp_left > 0) begin
                        rsp_ready = 1'b0;
                        bp_left--;
                    end else begin
                        rsp_ready = 1'b1;
                    end
                end
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_reg !== exp_idx || rsp_data !== regs[exp_idx] ||
                    rsp_last !== (!dump || exp_idx == 4'd15)) begin
                    errors++;
                    $display("FAIL response: got r%0d %h last=%b want r%0d %h last=%b",
                             rsp_reg, rsp_data, rsp_last, exp_idx, regs[exp_idx],
                             !dump || exp_idx == 4'd15);
                end
                n_rsp++;
                exp_idx++;
            end
            if (rsp_valid && !rsp_ready) stalls++;
            p_stall = rsp_valid && !rsp_ready;
            p_valid = rsp_valid; p_reg = rsp_reg; p_data = rsp_data; p_last = rsp_last;
            // Target model: rDEST only settles S0 cycles after the exec pulse.
            tg_to_visor_reg = (have_exec && cyc >= exec_cyc + S0 + 1) ? regs[exec_idx]
                                                                       : 16'($urandom);
            @(negedge sysclk);
        end
        checks++;
        if (!done || n_rsp != n_exp || restores != 1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_end: done=%b rsp=%0d restores=%0d ready=%b want 1 %0d 1 1",
                     done, n_rsp, restores, req_ready, n_exp);
        end
        if (exact) begin
            checks++;
            if (div_cycles != 7 + S0 || first_valid != 5 + S0) begin
                errors++;
                $display("FAIL latency: divert=%0d valid_at=%0d want %0d %0d", div_cycles,
                         first_valid, 7 + S0, 5 + S0);
            end
        end
        if (bp_mode == 1) begin
            checks++;
            if (stalls != 5) begin
                errors++;
                $display("FAIL stall_count: got %0d want 5", stalls);
            end
        end
    endtask

    task automatic test_single_r7();
        tg_halted = 1'b1;
        regs[7] = 16'h1234;
        exr_shadow = 16'hbeef;
        run_txn(1'b0, 4'd7, 0, 1'b1);
    endtask

    task automatic test_dump();
        for (int i = 0; i < 16; i++) regs[i] = 16'ha000 + 16'(i);
        exr_shadow = 16'($urandom);
        run_txn(1'b1, 4'd0, 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        exr_shadow = 16'($urandom);
        run_txn(1'b0, 4'd5, 1, 1'b0);
        run_txn(1'b1, 4'd0, 1, 1'b0);
    endtask

    task automatic test_errors();
        tg_halted = 1'b0;
        req_valid = 1'b1; req_reg = 4'd2; req_dump = 1'b0;
        @(negedge sysclk);
        req_valid = 1'b0;
        checks++;
        if ({err, busy, divert_code_bus, req_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL not_halted: err/busy/divert/ready=%b want 1001",
                     {err, busy, divert_code_bus, req_ready});
        end
        @(negedge sysclk);
        tg_halted = 1'b1;
        run_txn(1'b0, 4'($urandom_range(0, 15)), 0, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
            exr_shadow = 16'($urandom);
            run_txn(1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic seen;
        seen = 0;
        req_valid = 1'b1; req_reg = 4'd3; req_dump = 1'b0; rsp_ready = 1'b1;
        @(negedge sysclk);
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (tg_force_exec) begin
                seen = 1;
                break;
            end
            @(negedge sysclk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_exec: exec pulse seen=%b want 1", seen);
        end
        sysreset = 1'b1;
        @(negedge sysclk);
        sysreset = 1'b0;
        checks++;
        if ({req_ready, busy, divert_code_bus, tg_debug_hold, tg_force_load_exr,
             tg_force_exec, rsp_valid} !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_reset: got %b want 1000000", {req_ready, busy, divert_code_bus,
                     tg_debug_hold, tg_force_load_exr, tg_force_exec, rsp_valid});
        end
        @(negedge sysclk);
    endtask

    task automatic test_param_sweep();
        int n_rsp, exec_cyc, restores;
        logic [3:0]  exp_idx, exec_idx;
        logic [31:0] exr;
        logic        p_valid, have_exec, done;
        n_rsp = 0; exec_cyc = -100; restores = 0; exp_idx = '0; exec_idx = '0; exr = '0;
        p_valid = 0; have_exec = 0; done = 0;
        b_tg_halted = 1'b1; b_req_dump = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b_req_reg = (k == 0) ? 4'd8 : 4'd15;
            b_req_valid = 1'b1;
            @(negedge sysclk);
            b_req_valid = 1'b0;
            checks++;
            if ({b_err, b_busy, b_divert_code_bus} !== 3'b100) begin
                errors++;
                $display("FAIL bad_reg r%0d: err/busy/divert=%b want 100", b_req_reg,
                         {b_err, b_busy, b_divert_code_bus});
            end
        end
        for (int i = 0; i < 8; i++) b_regs[i] = $urandom;
        b_exr_shadow = $urandom;
        b_req_valid = 1'b1; b_req_dump = 1'b1; b_req_reg = 4'd5;
        @(negedge sysclk);
        b_req_valid = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (cyc == 1) begin
                checks++;
                if (b_err !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_err_clear: got %b want 0", b_err);
                end
            end
            if (!b_busy) begin
                done = 1;
                break;
            end
            if (b_tg_force_load_exr) begin
                checks++;
                if (n_rsp == 8) begin
                    restores++;
                    if (b_tg_code_in !== b_exr_shadow) begin
                        errors++;
                        $display("FAIL sweep_restore: got %h want %h", b_tg_code_in,
                                 b_exr_shadow);
                    end
                end else begin
                    exr = b_tg_code_in;
                    if (b_tg_code_in !== (32'h3c00 | 32'(exp_idx))) begin
                        errors++;
                        $display("FAIL sweep_load: got %h want %h", b_tg_code_in,
                                 32'h3c00 | 32'(exp_idx));
                    end
                end
            end
            if (b_tg_force_exec) begin
                exec_cyc = cyc; exec_idx = exr[3:0]; have_exec = 1;
            end
            if (b_rsp_valid && !p_valid) begin
                checks++;
                if (cyc != exec_cyc + S1 + 2) begin
                    errors++;
                    $display("FAIL sweep_timing: valid at %0d want %0d", cyc,
                             exec_cyc + S1 + 2);
                end
            end
            b_rsp_ready = 1'($urandom_range(0, 1));
            if (b_rsp_valid && b_rsp_ready) begin
                checks++;
                if (b_rsp_reg !== exp_idx || b_rsp_data !== b_regs[exp_idx[2:0]] ||
                    b_rsp_last !== (exp_idx == 4'd7)) begin
                    errors++;
                    $display("FAIL sweep_rsp: got r%0d %h last=%b want r%0d %h last=%b",
                             b_rsp_reg, b_rsp_data, b_rsp_last, exp_idx,
                             b_regs[exp_idx[2:0]], exp_idx == 4'd7);
                end
                n_rsp++;
                exp_idx++;
            end
            p_valid = b_rsp_valid;
            b_tg_to_visor_reg = (have_exec && cyc >= exec_cyc + S1 + 1) ? b_regs[exec_idx[2:0]]
                                                                         : $urandom;
            @(negedge sysclk);
        end
        checks++;
        if (!done || n_rsp != 8 || restores != 1) begin
            errors++;
            $display("FAIL sweep_end: done=%b rsp=%0d restores=%0d want 1 8 1", done, n_rsp,
                     restores);
        end
    endtask

    initial begin
        sysreset = 1'b1;
        req_valid = 0; req_reg = '0; req_dump = 0; tg_halted = 0; rsp_ready = 0;
        exr_shadow = '0; tg_to_visor_reg = '0;
        b_req_valid = 0; b_req_reg = '0; b_req_dump = 0; b_tg_halted = 0; b_rsp_ready = 0;
        b_exr_shadow = '0; b_tg_to_visor_reg = '0;
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) b_regs[i] = $urandom;
        test_reset();
        test_single_r7();
        test_dump();
        test_back_pressure();
        test_errors();
        test_random();
        test_reset_mid_sequence();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
